// File: rtl/alarm_key_entry.sv
// alarm_key_entry: collects four decimal key presses into an HH:MM buffer,
// validates the time and hands it to alarm_reg with a one-cycle load pulse.
// An inactivity timer on the 1 Hz tick abandons stale entries.
// Optional feature macro: TWELVE_HOUR_EN (hours 01..12 instead of 00..23).
//
// Handshake: key_strobe, set_alarm_key and one_second are single-cycle
// qualifiers sampled on the rising clock edge; there is no back-pressure.
// load_new_alarm is a single-cycle pulse and the new_alarm_* digits are
// stable and valid in that cycle (and hold afterwards until a new entry).
module alarm_key_entry #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_value,
  input  logic       key_strobe,
  input  logic       set_alarm_key,
  input  logic       one_second,
  output logic [3:0] new_alarm_ms_hr,
  output logic [3:0] new_alarm_ls_hr,
  output logic [3:0] new_alarm_ms_min,
  output logic [3:0] new_alarm_ls_min,
  output logic       load_new_alarm,
  output logic       entry_active,
  output logic       entry_error,
  output logic [2:0] digit_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ms_hr_q, ms_hr_d;
  logic [3:0] ls_hr_q, ls_hr_d;
  logic [3:0] ms_min_q, ms_min_d;
  logic [3:0] ls_min_q, ls_min_d;
  logic [2:0] count_q, count_d;
  logic [3:0] tmo_q, tmo_d;
  logic       load_q, load_d;
  logic       err_q, err_d;
  logic       active_q, active_d;

  logic       is_digit;
  logic [6:0] hour_val;
  logic       time_ok;

  // Decode the key and check the buffered time for validity
  always_comb begin
    is_digit = key_strobe && (key_value <= 4'd9);
    hour_val = 7'(ms_hr_q) * 7'd10 + 7'(ls_hr_q);
`ifdef TWELVE_HOUR_EN
    time_ok  = (ms_hr_q <= 4'd1) && (ls_hr_q <= 4'd9) &&
               (hour_val >= 7'd1) && (hour_val <= 7'd12) &&
               (ms_min_q <= 4'd5) && (ls_min_q <= 4'd9);
`else
    time_ok  = (ms_hr_q <= 4'd2) && (ls_hr_q <= 4'd9) &&
               (hour_val <= 7'd23) &&
               (ms_min_q <= 4'd5) && (ls_min_q <= 4'd9);
`endif
  end

  // Next-state, buffer, counter and output-pulse logic
  always_comb begin
    state_d  = state_q;
    ms_hr_d  = ms_hr_q;
    ls_hr_d  = ls_hr_q;
    ms_min_d = ms_min_q;
    ls_min_d = ls_min_q;
    count_d  = count_q;
    tmo_d    = tmo_q;
    load_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          ms_hr_d  = 4'd0;
          ls_hr_d  = 4'd0;
          ms_min_d = 4'd0;
          ls_min_d = key_value;
          count_d  = 3'd1;
          tmo_d    = 4'd0;
          state_d  = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (set_alarm_key) begin
          // Commit takes priority over any key in the same cycle
          if ((count_q == 3'd4) && time_ok) begin
            load_d  = 1'b1;
            state_d = S_LOAD;
          end else begin
            err_d    = 1'b1;
            ms_hr_d  = 4'd0;
            ls_hr_d  = 4'd0;
            ms_min_d = 4'd0;
            ls_min_d = 4'd0;
            count_d  = 3'd0;
            tmo_d    = 4'd0;
            state_d  = S_IDLE;
          end
        end else if (is_digit) begin
          // A digit beats a simultaneous tick and restarts the timer
          ms_hr_d  = ls_hr_q;
          ls_hr_d  = ms_min_q;
          ms_min_d = ls_min_q;
          ls_min_d = key_value;
          count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
          tmo_d    = 4'd0;
        end else if (one_second) begin
          if (tmo_q == 4'(TIMEOUT_SEC - 1)) begin
            err_d    = 1'b1;
            ms_hr_d  = 4'd0;
            ls_hr_d  = 4'd0;
            ms_min_d = 4'd0;
            ls_min_d = 4'd0;
            count_d  = 3'd0;
            tmo_d    = 4'd0;
            state_d  = S_IDLE;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
      end
      S_LOAD: begin
        count_d = 3'd0;
        tmo_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    active_d = (state_d == S_ENTRY);
  end

  // State and output registers; reset discards any entry immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ms_hr_q  <= 4'd0;
      ls_hr_q  <= 4'd0;
      ms_min_q <= 4'd0;
      ls_min_q <= 4'd0;
      count_q  <= 3'd0;
      tmo_q    <= 4'd0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ms_hr_q  <= ms_hr_d;
      ls_hr_q  <= ls_hr_d;
      ms_min_q <= ms_min_d;
      ls_min_q <= ls_min_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      load_q   <= load_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign new_alarm_ms_hr  = ms_hr_q;
  assign new_alarm_ls_hr  = ls_hr_q;
  assign new_alarm_ms_min = ms_min_q;
  assign new_alarm_ls_min = ls_min_q;
  assign load_new_alarm   = load_q;
  assign entry_error      = err_q;
  assign entry_active     = active_q;
  assign digit_count      = count_q;
  assign state_dbg        = state_q;

endmodule

// File: doc/alarm_key_entry.md
Name: alarm_key_entry

Overview:
- Keypad-side producer for the alarm register's load interface: collects four decimal key presses into an HH:MM buffer, validates the time, then drives new_alarm_ms_hr/ls_hr/ms_min/ls_min with a single-cycle load_new_alarm pulse.
- Sits between the keypad scanner and alarm_reg; an inactivity timer driven by the 1 Hz tick abandons stale entries.

Parameters:
- TIMEOUT_SEC, 10, one_second ticks without a key press in ENTRY before the buffer is discarded (1..15).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- key_value  in  4  key code; 0-9 are digits, 10-15 are non-digit keys
- key_strobe  in  1  one-cycle pulse qualifying key_value
- set_alarm_key  in  1  one-cycle pulse: commit the entry
- one_second  in  1  one-cycle 1 Hz tick from the time generator
- new_alarm_ms_hr  out  4  buffered hour tens digit
- new_alarm_ls_hr  out  4  buffered hour units digit
- new_alarm_ms_min  out  4  buffered minute tens digit
- new_alarm_ls_min  out  4  buffered minute units digit
- load_new_alarm  out  1  one-cycle commit pulse to alarm_reg
- entry_active  out  1  high while in ENTRY
- entry_error  out  1  one-cycle pulse on rejected commit or timeout
- digit_count  out  3  digits captured, 0..4

Behaviour:
- Reset (async, active-high): state IDLE; all four digit outputs 4'd0; digit_count 0; timeout counter 0; load_new_alarm, entry_error, entry_active all 0. Asserting reset mid-entry or during LOAD discards everything immediately.
- States: IDLE, ENTRY, LOAD.
- IDLE:
  - key_strobe with key_value 0-9: clear buffer, shift the digit into ls_min, digit_count=1, timeout counter=0, go to ENTRY.
  - Non-digit keys, set_alarm_key and one_second are ignored.
- ENTRY (entry_active=1):
  - Digit strobe: shift left one digit: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key_value. digit_count increments and saturates at 4; a 5th and later digit still shifts, discarding the oldest. Timeout counter clears.
  - Non-digit key_strobe: ignored, and does not clear the timeout counter.
  - one_second with no key in the same cycle: timeout counter increments. When it reaches TIMEOUT_SEC: clear buffer, digit_count=0, pulse entry_error, go to IDLE.
  - set_alarm_key: go to LOAD only if digit_count==4 and the time is valid. Valid means ms_hr<=2, ls_hr<=9, hour value<=23, ms_min<=5, ls_min<=9. Otherwise pulse entry_error, clear buffer, digit_count=0, go to IDLE.
  - Simultaneous set_alarm_key and key_strobe: the commit wins and the key is dropped.
  - Simultaneous digit key_strobe and one_second: the key wins and the counter clears.
- LOAD:
  - load_new_alarm=1 for exactly this one cycle, with digit outputs stable and equal to the validated values.
  - Next cycle: IDLE, digit_count=0; digit outputs hold their values until the next entry starts.
  - Inputs are ignored during LOAD.
- Latency: load_new_alarm is asserted the cycle after the set_alarm_key pulse is sampled. entry_error is asserted the cycle after its cause.
- All outputs are registered.

Optional Feature:
- Macro: TWELVE_HOUR_EN.
- Defined: hour validity becomes 01..12 (ms_hr<=1, hour value 1..12); 00 and 13-23 are rejected with entry_error.
- Undefined: 24-hour validation 00..23 as above.

Test Plan:
- Reset mid-entry: keys 1,2 then reset -> digit_count=0, outputs 0000, entry_active=0 immediately (asynchronous).
- Keys 0,7,3,0 then set_alarm_key -> next cycle load_new_alarm=1 for one cycle with outputs 0,7,3,0; then IDLE, outputs held at 0730.
- Keys 2,4,0,0 + commit -> entry_error pulse, no load, outputs 0000. With TWELVE_HOUR_EN, keys 1,3,0,0 + commit -> error, and 1,2,0,0 + commit -> load.
- Keys 1,2,3 + commit -> error (digit_count=3). Keys 1,2,3,4,5 + commit -> load 2,3,4,5.
- TIMEOUT_SEC=10: key 5, then 10 one_second ticks with no keys -> entry_error on the 10th, IDLE, buffer cleared. A digit on tick 9 restarts the count.
- Same-cycle set_alarm_key and digit key after 1,1,4,5 -> load 1,1,4,5, digit dropped. Non-digit key 12 in ENTRY -> buffer unchanged.
